shift_seq_32: RTL and testbench

Sequential counterpart to the ALU's single-cycle 32-bit shifter. It shifts one bit per clock under a start/busy/done handshake, for multi-cycle ALU paths such as SLLV, SRLV and SRAV. The carry output is the bit actually shifted out on the last step, which gives the ALU an exact C flag. Sits beside the ALU; the control unit issues start and stalls on busy.

---
 rtl/shift_seq_32.sv | 139 +++++++++++++
 tb/tb_shift_seq_32.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/shift_seq_32.sv
// shift_seq_32: sequential 32-bit shifter, one bit per clock, start/busy/done handshake.
// Ops: LRRA 00=SLL, 01=SRL, 10=SRA, 11=rotate right when ROTATE_EN is defined,
// otherwise 11 is a pass-through that finishes immediately with Y=D.
// C_BS holds the last bit shifted out (0 when no step was taken).
// Optional macro: ROTATE_EN
module shift_seq_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] D,
    input  logic [CNT_W-1:0] shift_val,
    input  logic [1:0]       LRRA,
    output logic [WIDTH-1:0] Y,
    output logic             C_BS,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] y_reg, y_next;
    logic             c_reg, c_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       op_reg, op_next;

    // One-bit step datapath, derived from the latched op
    logic             shift_left;
    logic             fill_bit;
    logic             step_c;
    logic [WIDTH-1:0] step_y;

    // Select direction, the bit entering at the MSB, and the bit falling out
    always_comb begin
        shift_left = (op_reg == OP_SLL);
        fill_bit   = 1'b0;
        if (op_reg == OP_SRA) begin
            fill_bit = y_reg[WIDTH-1];
        end
`ifdef ROTATE_EN
        if (op_reg == OP_ROR) begin
            fill_bit = y_reg[0];
        end
`endif
        step_c = shift_left ? y_reg[WIDTH-1] : y_reg[0];
    end

    // Per-bit neighbour mux: left takes the lower neighbour, right the upper one
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign step_y[gi] = shift_left ? 1'b0 : y_reg[gi+1];
            end else if (gi == WIDTH - 1) begin : g_msb
                assign step_y[gi] = shift_left ? y_reg[gi-1] : fill_bit;
            end else begin : g_mid
                assign step_y[gi] = shift_left ? y_reg[gi-1] : y_reg[gi+1];
            end
        end
    endgenerate

    // Next-state and datapath update for the handshake FSM
    always_comb begin
        state_next = state_reg;
        y_next     = y_reg;
        c_next     = c_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    y_next   = D;
                    cnt_next = shift_val;
                    op_next  = LRRA;
                    c_next   = 1'b0;
                    if (shift_val == '0) begin
                        state_next = ST_DONE;
                    end
`ifndef ROTATE_EN
                    else if (LRRA == OP_ROR) begin
                        // Pass-through op: no steps regardless of amount
                        state_next = ST_DONE;
                    end
`endif
                    else begin
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                y_next   = step_y;
                c_next   = step_c;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            y_reg     <= '0;
            c_reg     <= 1'b0;
            cnt_reg   <= '0;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            c_reg     <= c_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
        end
    end

    assign Y    = y_reg;
    assign C_BS = c_reg;
    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_shift_seq_32.sv
// Directed testbench for shift_seq_32. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Honours ROTATE_EN like the design.
module tb_shift_seq_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] D;
    logic [4:0]  shift_val;
    logic [1:0]  LRRA;
    logic [31:0] Y;
    logic        C_BS;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    shift_seq_32 #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .D         (D),
        .shift_val (shift_val),
        .LRRA      (LRRA),
        .Y         (Y),
        .C_BS      (C_BS),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to done. elat is the cycle (counted
    // from the accepting edge) in which done must be high. With disturb set,
    // start stays high with a different operand until done is seen.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] sv,
                          input logic [1:0] op, input logic [31:0] ey, input logic ec,
                          input int elat, input bit disturb);
        int          cyc;
        int          busy_cyc;
        bit          seen;
        logic [31:0] y_done;
        logic        c_done;
        cyc      = 0;
        busy_cyc = 0;
        seen     = 1'b0;
        y_done   = '0;
        c_done   = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        D         = d;
        shift_val = sv;
        LRRA      = op;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (done) begin
                seen   = 1'b1;
                y_done = Y;
                c_done = C_BS;
            end
            // Operands are scrambled after acceptance; they must not matter
            D         = ~d;
            shift_val = sv + 5'd3;
            LRRA      = op ^ 2'b01;
            start     = disturb && !seen;
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(cyc), 32'(elat));
        check({tag, ".busy_cycles"}, 32'(busy_cyc), 32'(elat));
        check({tag, ".Y"}, y_done, ey);
        check({tag, ".C_BS"}, 32'(c_done), 32'(ec));
        @(negedge clk);
        check({tag, ".hold_Y"}, Y, ey);
        check({tag, ".hold_C"}, 32'(C_BS), 32'(ec));
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        $display("op %s D=0x%08h n=%0d LRRA=%0d -> Y=0x%08h C=%0b latency=%0d",
                 tag, d, sv, op, y_done, c_done, cyc);
    endtask

    initial begin
        int done_cnt;
        reset     = 1'b1;
        start     = 1'b0;
        D         = '0;
        shift_val = '0;
        LRRA      = '0;
        repeat (3) @(negedge clk);
        check("reset.Y", Y, 32'd0);
        check("reset.C_BS", 32'(C_BS), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        $display("reset released");

        run_op("sll4",     32'h0000_0001, 5'd4,  2'b00, 32'h0000_0010, 1'b0, 5,  1'b0);
        run_op("sra31",    32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0, 32, 1'b0);
        run_op("srl1",     32'h0000_0003, 5'd1,  2'b01, 32'h0000_0001, 1'b1, 2,  1'b0);
        run_op("sll1",     32'h8000_0001, 5'd1,  2'b00, 32'h0000_0002, 1'b1, 2,  1'b0);
        run_op("zero_sll", 32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 1'b0, 1,  1'b0);
        run_op("srl1b",    32'h0000_0003, 5'd1,  2'b01, 32'h0000_0001, 1'b1, 2,  1'b0);
        run_op("zero_srl", 32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF, 1'b0, 1,  1'b0);
        run_op("zero_sra", 32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF, 1'b0, 1,  1'b0);
        run_op("zero_op3", 32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, 1'b0, 1,  1'b0);
        run_op("srl31",    32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 1'b0, 32, 1'b0);
        run_op("sra4",     32'hF000_000F, 5'd4,  2'b10, 32'hFF00_0000, 1'b1, 5,  1'b0);
        run_op("sll31",    32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 1'b1, 32, 1'b0);
        run_op("busy_start", 32'h0000_0001, 5'd4, 2'b00, 32'h0000_0010, 1'b0, 5, 1'b1);
`ifdef ROTATE_EN
        run_op("ror1",     32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000, 1'b1, 2,  1'b0);
        run_op("ror5",     32'h0000_0001, 5'd5,  2'b11, 32'h0800_0000, 1'b0, 6,  1'b0);
`else
        run_op("pass1",    32'h0000_0001, 5'd1,  2'b11, 32'h0000_0001, 1'b0, 1,  1'b0);
        run_op("pass5",    32'h0000_0001, 5'd5,  2'b11, 32'h0000_0001, 1'b0, 1,  1'b0);
`endif

        // Reset in the middle of a shift aborts with no done pulse
        @(negedge clk);
        start     = 1'b1;
        D         = 32'hF000_00F0;
        shift_val = 5'd10;
        LRRA      = 2'b00;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort.Y", Y, 32'd0);
        check("abort.C_BS", 32'(C_BS), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        reset    = 1'b0;
        done_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort.no_done", 32'(done_cnt), 32'd0);
        check("abort.idle_busy", 32'(busy), 32'd0);
        $display("op abort_mid_shift -> Y=0x%08h C=%0b done_pulses=%0d", Y, C_BS, done_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
